// File: rtl/riu_pkg.sv
// Shared definitions for the instruction encoder: instruction-type coding,
// base opcodes and the canonical NOP word.
package riu_pkg;

  typedef enum logic [1:0] {
    TYPE_NONE = 2'd0,
    TYPE_R    = 2'd1,
    TYPE_I    = 2'd2,
    TYPE_U    = 2'd3
  } instr_t;

  localparam logic [6:0]  OP_R = 7'b0110011;
  localparam logic [6:0]  OP_I = 7'b0010011;
  localparam logic [6:0]  OP_U = 7'b0110111;
  localparam logic [31:0] NOP  = 32'h0000_0013;

endpackage

// File: rtl/enc_fifo.sv
// Synchronous DEPTH-entry FIFO holding {instr, addr} words; head reads as zero
// when empty, and a push into a full FIFO is ignored even alongside a pop.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; occupancy gates what is visible at the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/instr_enc.sv
// Encodes R/I/U field tuples into 32-bit words tagged with sequential byte
// addresses and queues them in a FIFO. Optional ENC_CHECK_EN drops type-0 tuples and flags err.
module instr_enc
  import riu_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_type,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [2:0]             in_funct3,
  input  logic [6:0]             in_funct7,
  input  logic [11:0]            in_imm12,
  input  logic [19:0]            in_imm20,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_addr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  function automatic logic [31:0] encode(
    input logic [1:0]  t,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [11:0] imm12,
    input logic [19:0] imm20
  );
    logic [31:0] w;
    case (instr_t'(t))
      TYPE_R:  w = {f7, rs2, rs1, f3, rd, OP_R};
      TYPE_I:  w = {imm12, rs1, f3, rd, OP_I};
      TYPE_U:  w = {imm20, rd, OP_U};
      default: w = NOP;
    endcase
    return w;
  endfunction

  logic [31:0] word_p0;
  logic [31:0] addr_p0;
  logic        accept;
  logic        reject;
  logic        push;
  logic        full;
  logic        empty;
  logic [63:0] head;

  // Stage 0: combinational encode of the presented tuple
  assign word_p0 = encode(in_type, in_rd, in_rs1, in_rs2, in_funct3,
                          in_funct7, in_imm12, in_imm20);
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && !reject;

`ifdef ENC_CHECK_EN
  logic err_p1;

  assign reject = accept && (instr_t'(in_type) == TYPE_NONE);
  assign err    = err_p1;

  always_ff @(posedge clk) begin
    if (rst) err_p1 <= 1'b0;
    else     err_p1 <= reject;
  end
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  // Address advances only for words that actually enter the FIFO.
  always_ff @(posedge clk) begin
    if (rst)       addr_p0 <= BASE_ADDR;
    else if (push) addr_p0 <= addr_p0 + 32'd4;
  end

  // Stage 1: registered FIFO, head drives the outputs
  enc_fifo #(
    .DEPTH (DEPTH),
    .W     (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (out_ready),
    .din   ({word_p0, addr_p0}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_instr = head[63:32];
  assign out_addr  = head[31:0];

endmodule

// File: tb/tb_instr_enc.sv
// Self-checking bench for instr_enc: vector table plus scoreboard queue, with
// hand sequences for backpressure, type-0 handling, push+pop and reset.
module tb_instr_enc;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_type;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [11:0] in_imm12;
  logic [19:0] in_imm20;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [$clog2(DEPTH):0] count;
  logic        err;

  instr_enc #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm12(in_imm12), .in_imm20(in_imm20),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm12;
    logic [19:0] imm20;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } sb_t;

  vec_t        vecs [6];
  vec_t        v0;
  sb_t         q [$];
  logic [31:0] exp_addr;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake at the head must match the scoreboard front.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mon_unexpected: got %0h @%0h expected no output", out_instr, out_addr);
      end else begin
        sb_t e;
        e = q.pop_front();
        check("mon_instr", {32'h0, out_instr}, {32'h0, e.instr});
        check("mon_addr",  {32'h0, out_addr},  {32'h0, e.addr});
      end
    end
  end

  task automatic send(input vec_t v, input bit pushes);
    bit ok;
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_type   = v.t;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_imm12  = v.imm12;
    in_imm20  = v.imm20;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (pushes) begin
          q.push_back({v.exp, exp_addr});
          exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    q.delete();
    exp_addr = BASE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_instr;

    vecs[0] = '{2'd1, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 12'h000, 20'h00000, 32'h002081B3};
    vecs[1] = '{2'd2, 5'd5,  5'd0,  5'd0,  3'd0, 7'h00, 12'h7FF, 20'h00000, 32'h7FF00293};
    vecs[2] = '{2'd3, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 12'h000, 20'h12345, 32'h123450B7};
    vecs[3] = '{2'd1, 5'd31, 5'd31, 5'd31, 3'd7, 7'h20, 12'h000, 20'h00000, 32'h41FFFFB3};
    vecs[4] = '{2'd2, 5'd7,  5'd10, 5'd5,  3'd2, 7'h7F, 12'h800, 20'h00000, 32'h80052393};
    vecs[5] = '{2'd3, 5'd0,  5'd31, 5'd31, 3'd7, 7'h7F, 12'hFFF, 20'hFFFFF, 32'hFFFFF037};
    v0      = '{2'd0, 5'd9,  5'd9,  5'd9,  3'd1, 7'h11, 12'h123, 20'h45678, 32'h00000013};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_type = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm12 = '0; in_imm20 = '0;
    exp_addr = BASE;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_count",    {32'h0, 29'h0, count}, 64'd0);
    check("rst_valid",    {63'h0, out_valid},    64'd0);
    check("rst_instr",    {32'h0, out_instr},    64'd0);
    check("rst_addr",     {32'h0, out_addr},     64'd0);
    check("rst_err",      {63'h0, err},          64'd0);
    check("rst_in_ready", {63'h0, in_ready},     64'd1);

    // First word visible the cycle after acceptance
    out_ready = 1'b1;
    send(vecs[0], 1'b1);
    check("lat_valid", {63'h0, out_valid},   64'd1);
    check("lat_instr", {32'h0, out_instr},   {32'h0, 32'h002081B3});
    check("lat_addr",  {32'h0, out_addr},    {32'h0, BASE});
    repeat (3) @(posedge clk);
    #1;

    do_reset();
    for (int i = 1; i < 6; i++) send(vecs[i], 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("table_drained", 64'(q.size()), 64'd0);

    // Type-0 tuple
    do_reset();
`ifdef ENC_CHECK_EN
    send(v0, 1'b0);
    check("t0_err_pulse", {63'h0, err}, 64'd1);
    check("t0_no_push",   {32'h0, 29'h0, count}, 64'd0);
    @(posedge clk);
    #1;
    check("t0_err_clear", {63'h0, err}, 64'd0);
`else
    send(v0, 1'b1);
    check("t0_err_low",   {63'h0, err}, 64'd0);
`endif
    send(vecs[2], 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("t0_drained", 64'(q.size()), 64'd0);

    // Backpressure: 4 fit, the fifth waits for space
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(vecs[i], 1'b1);
    check("bp_count",    {32'h0, 29'h0, count}, 64'd4);
    check("bp_in_ready", {63'h0, in_ready},     64'd0);
    check("bp_head",     {32'h0, out_instr},    {32'h0, q[0].instr});
    hold_instr = out_instr;
    fork
      send(vecs[4], 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_instr", {32'h0, out_instr}, {32'h0, hold_instr});
        check("bp_hold_addr",  {32'h0, out_addr},  {32'h0, BASE});
        check("bp_hold_count", {32'h0, 29'h0, count}, 64'd4);
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    check("bp_drained", 64'(q.size()), 64'd0);
    check("bp_next_addr", {32'h0, exp_addr}, {32'h0, BASE + 32'd20});

    // Push and pop together at count 2
    do_reset();
    out_ready = 1'b0;
    send(vecs[1], 1'b1);
    send(vecs[2], 1'b1);
    check("pp_count_before", {32'h0, 29'h0, count}, 64'd2);
    in_valid = 1'b1; in_type = vecs[3].t; in_rd = vecs[3].rd; in_rs1 = vecs[3].rs1;
    in_rs2 = vecs[3].rs2; in_funct3 = vecs[3].f3; in_funct7 = vecs[3].f7;
    in_imm12 = vecs[3].imm12; in_imm20 = vecs[3].imm20;
    q.push_back({vecs[3].exp, exp_addr});
    exp_addr  = exp_addr + 32'd4;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("pp_count_after", {32'h0, 29'h0, count}, 64'd2);

    // Reset with three queued and a push/pop pending
    send(vecs[5], 1'b1);
    check("rst3_count_before", {32'h0, 29'h0, count}, 64'd3);
    in_valid  = 1'b1;
    in_type   = 2'd1;
    out_ready = 1'b1;
    do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rst3_count",    {32'h0, 29'h0, count}, 64'd0);
    check("rst3_valid",    {63'h0, out_valid},    64'd0);
    check("rst3_instr",    {32'h0, out_instr},    64'd0);
    check("rst3_addr",     {32'h0, out_addr},     64'd0);
    check("rst3_in_ready", {63'h0, in_ready},     64'd1);
    out_ready = 1'b1;
    send(vecs[2], 1'b1);
    check("rst3_next_addr", {32'h0, out_addr}, {32'h0, BASE});
    repeat (4) @(posedge clk);
    #1;
    check("final_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_enc.md
INSTR_ENC -- requirements
Module: instr_enc

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address given to the first emitted word.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  field tuple present.
REQ-006 in_ready  output  1  tuple accepted when in_valid && in_ready at clk edge.
REQ-007 in_type  input  2  0 none, 1 R, 2 I, 3 U (same coding as the decoder's instrT).
REQ-008 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-009 in_funct3  input  3; in_funct7  input  7.
REQ-010 in_imm12  input  12; in_imm20  input  20.
REQ-011 out_valid  output  1  FIFO head valid.
REQ-012 out_ready  input  1  head consumed when out_valid && out_ready at clk edge.
REQ-013 out_instr  output  32  encoded word at head.
REQ-014 out_addr  output  32  byte address of head word.
REQ-015 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-016 err  output  1  one-cycle pulse on a rejected tuple (only with ENC_CHECK_EN).

Function
REQ-017 Type R SHALL encode {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
REQ-018 Type I SHALL encode {imm12, rs1, funct3, rd, 7'b0010011}; rs2/funct7 ignored.
REQ-019 Type U SHALL encode {imm20, rd, 7'b0110111}; other fields ignored.
REQ-020 Encoding combinational from inputs; word registered into FIFO tail on acceptance.
REQ-021 Latency: tuple accepted at edge N SHALL appear at out_* after edge N (valid in cycle N+1) if FIFO was empty; no combinational input-to-output path.
REQ-022 in_ready SHALL equal (count != DEPTH); when full no push, even if a pop occurs same cycle.
REQ-023 Simultaneous push and pop when not full/empty: count unchanged, both take effect.
REQ-024 out_valid SHALL equal (count != 0); out_instr/out_addr SHALL hold stable while out_valid && !out_ready.
REQ-025 Each pushed word SHALL take address BASE_ADDR + 4*k, k = pushed-word index since reset; address counter wraps mod 2^32.
REQ-026 Pointers wrap mod DEPTH; out_* when empty SHALL be 0.
REQ-027 Rejected tuples SHALL not be pushed and SHALL not advance the address counter.

Reset
REQ-028 On rst high at an edge: FIFO emptied, count=0, out_valid=0, out_instr=0, out_addr=0, err=0, address counter=BASE_ADDR, in_ready=1 next cycle.
REQ-029 rst SHALL override simultaneous push/pop; in-flight entries discarded.

Configuration
REQ-030 Macro ENC_CHECK_EN defined: type 0 tuple is accepted (in_ready handshake completes), dropped, err pulses 1 cycle after.
REQ-031 ENC_CHECK_EN undefined: type 0 encodes as NOP 32'h0000_0013 and is pushed normally; err tied 0.

Structure
REQ-032 Shared package riu_pkg SHALL hold the instruction-type enum (NONE/R/I/U), opcode constants OP_R=7'b0110011, OP_I=7'b0010011, OP_U=7'b0110111, and NOP constant.
REQ-033 One sub-module enc_fifo (parametric DEPTH x 64-bit synchronous FIFO, word+addr) SHALL be instantiated; encode logic stays in instr_enc.

Verification
REQ-034 R: rd=3, rs1=1, rs2=2, f3=0, f7=0 -> out_instr 32'h002081B3, out_addr 0, valid cycle after accept.
REQ-035 I then U: I rd=5, rs1=0, imm12=12'h7FF, f3=0 -> 32'h7FF00293 @0; U rd=1, imm20=20'h12345 -> 32'h123450B7 @4.
REQ-036 Backpressure: out_ready=0, push 5 tuples with DEPTH=4 -> 4 accepted, in_ready=0, count=4; release -> addresses 0,4,8,12 in order, fifth accepted as 16.
REQ-037 Type 0 tuple: with ENC_CHECK_EN -> err pulse, nothing pushed, next word keeps prior address; without -> 32'h00000013 pushed.
REQ-038 Push+pop same cycle at count=2 -> count stays 2; rst asserted with count=3 -> count=0, out_valid=0, next word at BASE_ADDR.
